pc: RTL and testbench



---
 rtl/pc.sv | 42 ++++
 tb/tb_pc.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/pc.sv
// pc: free-running program counter that steps by STEP and wraps to RESET_VAL past LAST_VAL
//   clk  : system clock, state advances on the rising edge
//   rst  : asynchronous active-high reset, forces pout to RESET_VAL
//   pout : current fetch address, driven straight from the counter register
module pc #(
    parameter int WIDTH     = 6,
    parameter int RESET_VAL = 0,
    parameter int STEP      = 1,
    parameter int LAST_VAL  = (1 << WIDTH) - 1
) (
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] pout
);
    localparam logic [WIDTH:0]   STEP_X  = (WIDTH+1)'(STEP);
    localparam logic [WIDTH:0]   LAST_X  = (WIDTH+1)'(LAST_VAL);
    localparam logic [WIDTH-1:0] RESET_W = WIDTH'(RESET_VAL);
    // A step wider than the whole range always wraps; guards against STEP truncating in WIDTH+1 bits.
    localparam bit               STEP_OK = STEP <= LAST_VAL;

    if (WIDTH < 1 || STEP < 1 || RESET_VAL < 0 || RESET_VAL > LAST_VAL ||
        longint'(LAST_VAL) > (longint'(1) << WIDTH) - 1) begin : g_bad_params
        $error("pc: illegal parameter combination");
    end

    logic [WIDTH-1:0] r_pout;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_next;

    // Sum carries an extra bit so the terminal comparison never sees a truncated value.
    always_comb begin
        w_sum  = {1'b0, r_pout} + STEP_X;
        w_next = (STEP_OK && w_sum <= LAST_X) ? w_sum[WIDTH-1:0] : RESET_W;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_pout <= RESET_W;
        else     r_pout <= w_next;
    end

    assign pout = r_pout;
endmodule

// File: tb/tb_pc.sv
// tb_pc: randomized self-checking bench for pc in default and stepped/offset configurations
module tb_pc;
    logic       clk;
    logic       rst;
    logic       rst_v;
    logic [5:0] pout;
    logic [3:0] pout_v;
    int checks;
    int errors;
    int n;

    pc dut (.clk(clk), .rst(rst), .pout(pout));
    pc #(.WIDTH(4), .STEP(3), .RESET_VAL(2), .LAST_VAL(14)) dut_v (.clk(clk), .rst(rst_v), .pout(pout_v));

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    // Reference values: default counts edges mod 64; variant visits 2,5,8,11,14 (five states).
    function automatic logic [5:0] exp_def(input int k);
        return 6'(k % 64);
    endfunction

    function automatic logic [3:0] exp_var(input int k);
        return 4'(2 + 3 * (k % 5));
    endfunction

    task automatic reset_both();
        @(negedge clk);
        rst = 1;
        rst_v = 1;
        @(negedge clk);
        rst = 0;
        rst_v = 0;
        n = 0;
    endtask

    task automatic test_reset();
        rst = 0;
        rst_v = 0;
        #1 rst = 1;
        rst_v = 1;
        #1;
        checks++;
        if (pout !== 6'd0) begin errors++; $display("FAIL reset_async got %0d want 0", pout); end
        checks++;
        if (pout_v !== 4'd2) begin errors++; $display("FAIL reset_async_v got %0d want 2", pout_v); end
        @(posedge clk);
        #1;
        checks++;
        if (pout !== 6'd0) begin errors++; $display("FAIL reset_edge_ignored got %0d want 0", pout); end
        @(posedge clk);
        #1;
        checks++;
        if (pout_v !== 4'd2) begin errors++; $display("FAIL reset_edge_ignored_v got %0d want 2", pout_v); end
    endtask

    task automatic test_count();
        reset_both();
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1 n++;
            checks++;
            if (pout !== exp_def(n)) begin errors++; $display("FAIL count edge %0d got %0d want %0d", n, pout, exp_def(n)); end
        end
    endtask

    task automatic test_wrap();
        while (n < 65) begin
            @(posedge clk);
            #1 n++;
            if (n >= 63) begin
                checks++;
                if (pout !== exp_def(n)) begin errors++; $display("FAIL wrap edge %0d got %0d want %0d", n, pout, exp_def(n)); end
            end
        end
    endtask

    task automatic test_long_run();
        reset_both();
        for (int i = 0; i < 120; i++) begin
            @(posedge clk);
            #1 n++;
            checks++;
            if (pout !== exp_def(n)) begin errors++; $display("FAIL long_run edge %0d got %0d want %0d", n, pout, exp_def(n)); end
        end
        checks++;
        if (pout !== 6'd56) begin errors++; $display("FAIL long_run_final got %0d want 56", pout); end
    endtask

    task automatic test_mid_reset();
        reset_both();
        repeat (37) @(posedge clk);
        #1;
        checks++;
        if (pout !== 6'd37) begin errors++; $display("FAIL mid_reset_pre got %0d want 37", pout); end
        #2 rst = 1;
        #1;
        checks++;
        if (pout !== 6'd0) begin errors++; $display("FAIL mid_reset_async got %0d want 0", pout); end
        @(negedge clk);
        rst = 0;
        @(posedge clk);
        #1;
        checks++;
        if (pout !== 6'd1) begin errors++; $display("FAIL mid_reset_release got %0d want 1", pout); end
        @(posedge clk);
        rst = 1;
        #1;
        checks++;
        if (pout !== 6'd0) begin errors++; $display("FAIL reset_on_edge got %0d want 0", pout); end
        @(negedge clk);
        rst = 0;
    endtask

    task automatic test_variant();
        reset_both();
        checks++;
        if (pout_v !== 4'd2) begin errors++; $display("FAIL variant_reset got %0d want 2", pout_v); end
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1 n++;
            checks++;
            if (pout_v !== exp_var(n)) begin errors++; $display("FAIL variant edge %0d got %0d want %0d", n, pout_v, exp_var(n)); end
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 8; r++) begin
            int len;
            len = $urandom_range(1, 150);
            reset_both();
            for (int i = 0; i < len; i++) begin
                @(posedge clk);
                #1 n++;
                checks++;
                if (pout !== exp_def(n) || pout_v !== exp_var(n))
                    begin errors++; $display("FAIL random run %0d edge %0d got %0d/%0d want %0d/%0d", r, n, pout, pout_v, exp_def(n), exp_var(n)); end
            end
            #($urandom_range(1, 3));
            rst = 1;
            rst_v = 1;
            #1;
            checks++;
            if (pout !== 6'd0 || pout_v !== 4'd2)
                begin errors++; $display("FAIL random_reset run %0d got %0d/%0d want 0/2", r, pout, pout_v); end
            @(negedge clk);
            rst = 0;
            rst_v = 0;
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        n = 0;
        test_reset();
        test_count();
        test_wrap();
        test_long_run();
        test_mid_reset();
        test_variant();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
